// File: rtl/crc_tx_pkg.sv
// Shared constants and state type for the CRC-16 transmit appender.
package crc_tx_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;
  localparam int          CRC16_BITS    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    DONE    = 2'd3
  } crc_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// One MSB-first step of the EPC Gen2 CRC-16 (x^16+x^12+x^5+1) register.
module crc16_lfsr_step
  import crc_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_next
);

  logic fb;

  assign fb       = bit_in ^ crc_in[15];
  assign crc_next = {crc_in[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/crc16_tx_appender.sv
// Streams a reply payload bit-serially and appends its inverted CRC-16, MSB first.
// Optional transmit self-check enabled by defining CRC16_TX_SELFCHECK_EN.
module crc16_tx_appender
  import crc_tx_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_crc_tx,
  input  logic             rst_crc_tx,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             pl_bit,
  output logic             pl_req,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      crc_out,
  output logic             crc_selfcheck_ok
);

  // The counter must also hold the 16 CRC bits when LEN_W is small.
  localparam int CNT_W = (LEN_W > 5) ? LEN_W : 5;

  crc_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      crc_reg, crc_nxt, crc_step, crc_cap;
  logic             cap_en, accept, start_acc;

  crc16_lfsr_step u_main_step (
    .crc_in  (crc_reg),
    .bit_in  (pl_bit),
    .crc_next(crc_step)
  );

  assign accept    = tx_valid & tx_ready;
  assign start_acc = (state == IDLE) & start;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    crc_nxt   = crc_reg;
    crc_cap   = crc_out;
    cap_en    = 1'b0;
    pl_req    = 1'b0;
    tx_valid  = 1'b0;
    tx_bit    = 1'b0;
    tx_last   = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          crc_nxt = CRC16_PRESET;
          if (payload_len != '0) begin
            state_nxt = PAYLOAD;
            cnt_nxt   = CNT_W'(payload_len);
          end else begin
            state_nxt = CRC;
            cnt_nxt   = CNT_W'(CRC16_BITS);
            crc_cap   = ~CRC16_PRESET;
            cap_en    = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_bit   = pl_bit;
        pl_req   = tx_ready;
        if (tx_ready) begin
          crc_nxt = crc_step;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_nxt = CRC;
            cnt_nxt   = CNT_W'(CRC16_BITS);
            crc_cap   = ~crc_step;
            cap_en    = 1'b1;
          end
        end
      end
      CRC: begin
        tx_valid = 1'b1;
        tx_bit   = ~crc_reg[15];
        tx_last  = (cnt == CNT_W'(1));
        if (tx_ready) begin
          crc_nxt = {crc_reg[14:0], 1'b0};
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_crc_tx or posedge rst_crc_tx) begin
    if (rst_crc_tx) begin
      state   <= IDLE;
      cnt     <= '0;
      crc_reg <= CRC16_PRESET;
      crc_out <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      crc_reg <= crc_nxt;
      if (cap_en) crc_out <= crc_cap;
    end
  end

`ifdef CRC16_TX_SELFCHECK_EN
  logic [15:0] chk_reg, chk_next;

  // Re-absorbing the whole transmitted stream must land on the Gen2 residue.
  crc16_lfsr_step u_chk_step (
    .crc_in  (chk_reg),
    .bit_in  (tx_bit),
    .crc_next(chk_next)
  );

  always_ff @(posedge clk_crc_tx or posedge rst_crc_tx) begin
    if (rst_crc_tx) begin
      chk_reg          <= CRC16_PRESET;
      crc_selfcheck_ok <= 1'b0;
    end else if (start_acc) begin
      chk_reg          <= CRC16_PRESET;
      crc_selfcheck_ok <= 1'b0;
    end else if (accept) begin
      chk_reg <= chk_next;
      if (state == CRC && cnt == CNT_W'(1))
        crc_selfcheck_ok <= (chk_next == CRC16_RESIDUE);
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign crc_selfcheck_ok = 1'b0;
`endif

endmodule

// File: doc/crc16_tx_appender.md
# crc16_tx_appender

Transmit-side CRC-16 block for the tag reply path. Streams a reply payload from the reply generator to the FM0/Miller encoder bit by bit, computing the EPC Gen2 CRC-16 on the fly. After the payload it appends the 16-bit inverted CRC, MSB first. It sits between the reply generator and the line encoder and runs every reply that requires a CRC-16 (e.g. ACK/Read replies).

## Interface
Parameters:
- LEN_W, 8, width of payload bit count; max payload = 2^LEN_W − 1 bits

Ports:
- clk_crc_tx  in  1  block clock
- rst_crc_tx  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to begin a reply; ignored while busy
- payload_len  in  LEN_W  payload bit count, sampled on accepted start; 0 legal
- pl_bit  in  1  current payload bit; must be valid whenever pl_req may assert
- pl_req  out  1  payload bit consumed this cycle; source advances to next bit
- tx_ready  in  1  encoder accepts tx_bit this cycle
- tx_valid  out  1  tx_bit valid
- tx_bit  out  1  serial output bit
- tx_last  out  1  tx_bit is final CRC bit
- busy  out  1  reply in progress
- done  out  1  one-cycle pulse after final bit accepted
- crc_out  out  16  inverted CRC of payload (~crc register), valid once state reaches CRC
- crc_selfcheck_ok  out  1  see Configuration

## Operation
- CRC: polynomial x^16+x^12+x^5+1 (0x1021), preset 0xFFFF, MSB-first, transmitted value = ones-complement of register.
- State machine: IDLE, PAYLOAD, CRC, DONE.
  - IDLE: start → load crc_reg=0xFFFF, cnt=payload_len; go to PAYLOAD if payload_len≠0, else CRC with cnt=16.
  - PAYLOAD: tx_valid=1, tx_bit=pl_bit, pl_req=tx_ready. On accept: crc_reg ← {crc_reg[14:0],0} ^ (fb ? 0x1021 : 0), fb=pl_bit^crc_reg[15]; cnt−1. When the last payload bit is accepted, go to CRC and load cnt=16.
  - CRC: tx_valid=1, tx_bit=~crc_reg[15]. On accept, shift crc_reg left with 0 fill and decrement cnt. tx_last=1 when cnt==1. When the last bit is accepted, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in PAYLOAD, CRC and DONE.
- crc_out: ~crc_reg captured on PAYLOAD→CRC entry (or on start when len=0); held until the next start.
- Accept = tx_valid & tx_ready. With tx_ready low, all state, tx_bit and cnt hold and pl_req=0.
- start while busy: ignored, no effect.
- Reset (any time, including mid-reply): state IDLE, crc_reg=0xFFFF, cnt=0, crc_out=0x0000.
  - Outputs after reset: pl_req, tx_valid, tx_bit, tx_last, busy, done, crc_selfcheck_ok all 0.

## Timing
- start at edge N → tx_valid high from cycle N+1.
- Throughput: one bit per cycle with tx_ready held high.
- Reply of L payload bits with no backpressure: tx_valid high for L+16 cycles, then done in the following cycle. Earliest next start is the cycle after done.
- PAYLOAD→CRC transition introduces no bubble.
- pl_req, tx_valid, tx_bit and tx_last are decoded combinationally from registered state plus pl_bit/tx_ready. No combinational path from start.

## Configuration
- CRC16_TX_SELFCHECK_EN defined:
  - A second CRC register, preset 0xFFFF on start, absorbs every accepted tx_bit (payload and CRC).
  - crc_selfcheck_ok is registered: 1 on the done cycle if that register equals the residue 0x1D0F, else 0. It holds until the next start or reset.
- Macro undefined: no checker logic; crc_selfcheck_ok tied 0.

## Structure
- Shared package crc_tx_pkg holds:
  - CRC16_POLY=16'h1021, CRC16_PRESET=16'hFFFF, CRC16_RESIDUE=16'h1D0F, CRC16_BITS=16
  - the state enum (IDLE, PAYLOAD, CRC, DONE)
- One sub-module, crc16_lfsr_step: combinational next-register function (crc_in, bit_in → crc_next). It is used by the main register and the self-check register.

## Test plan
- ASCII "123456789" (72 bits, MSB-first per byte), tx_ready=1 → 72 payload bits echoed, then CRC bits 0xD64E; crc_out=0xD64E; done 89 cycles after start.
- payload_len=0 → 16 bits 0x0000 sent, tx_last on 16th, crc_out=0x0000, no pl_req.
- Backpressure: "123456789" with tx_ready low 3 cycles mid-payload and 2 cycles mid-CRC → identical bit stream, no pl_req while low, done delayed 5 cycles.
- start pulsed in PAYLOAD and CRC → ignored; stream and crc_out unchanged.
- Reset asserted mid-CRC → next cycle all outputs 0, state IDLE; a following start with len 0 yields 0x0000.
- With CRC16_TX_SELFCHECK_EN: any reply → crc_selfcheck_ok=1 at done. Forcing tx_bit corruption via a bench force on one CRC bit → 0.
